// File: rtl/demux_pkg.sv
// Shared constants for the registered 1-to-16 data demultiplexer.
// Imported by the bus interface and the demux top.
package demux_pkg;
  localparam int DEMUX_NUM_OUT   = 16;
  localparam int DEMUX_SEL_W     = 4;
  localparam int DEMUX_DEF_WIDTH = 8;
endpackage

// File: rtl/demux_if_if.sv
// Demux bus: one data word and select in, sixteen routed words out.
// master drives i/sel, slave is the demux.
interface demux_if_if
  import demux_pkg::*;
#(
  parameter int width = DEMUX_DEF_WIDTH
);
  logic [width-1:0]       i;
  logic [DEMUX_SEL_W-1:0] sel;
  logic [width-1:0]       o0, o1, o2, o3;
  logic [width-1:0]       o4, o5, o6, o7;
  logic [width-1:0]       o8, o9, o10, o11;
  logic [width-1:0]       o12, o13, o14, o15;

  modport master (
    output i, sel,
    input  o0, o1, o2, o3, o4, o5, o6, o7,
    input  o8, o9, o10, o11, o12, o13, o14, o15
  );

  modport slave (
    input  i, sel,
    output o0, o1, o2, o3, o4, o5, o6, o7,
    output o8, o9, o10, o11, o12, o13, o14, o15
  );
endinterface

// File: rtl/demux_if.sv
// Registered 1-to-16 demultiplexer: o[sel] <= i, all others <= 0.
// Synchronous active-high reset clears every output.
module demux_if
  import demux_pkg::*;
#(
  parameter int width = DEMUX_DEF_WIDTH,
  parameter int snum  = DEMUX_SEL_W
) (
  input logic       clk,
  input logic       rst,
  demux_if_if.slave b
);
  if (snum != DEMUX_SEL_W) begin : g_bad_snum
    $error("demux_if: snum must be 4");
  end

  logic [width-1:0] q [DEMUX_NUM_OUT];

  // Unknown or unmatched sel falls to the final else and clears all.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '{default: '0};
    end else begin
      q <= '{default: '0};
      if (b.sel == 4'd0)       q[0]  <= b.i;
      else if (b.sel == 4'd1)  q[1]  <= b.i;
      else if (b.sel == 4'd2)  q[2]  <= b.i;
      else if (b.sel == 4'd3)  q[3]  <= b.i;
      else if (b.sel == 4'd4)  q[4]  <= b.i;
      else if (b.sel == 4'd5)  q[5]  <= b.i;
      else if (b.sel == 4'd6)  q[6]  <= b.i;
      else if (b.sel == 4'd7)  q[7]  <= b.i;
      else if (b.sel == 4'd8)  q[8]  <= b.i;
      else if (b.sel == 4'd9)  q[9]  <= b.i;
      else if (b.sel == 4'd10) q[10] <= b.i;
      else if (b.sel == 4'd11) q[11] <= b.i;
      else if (b.sel == 4'd12) q[12] <= b.i;
      else if (b.sel == 4'd13) q[13] <= b.i;
      else if (b.sel == 4'd14) q[14] <= b.i;
      else if (b.sel == 4'd15) q[15] <= b.i;
      else q <= '{default: '0};
    end
  end

  assign b.o0  = q[0];
  assign b.o1  = q[1];
  assign b.o2  = q[2];
  assign b.o3  = q[3];
  assign b.o4  = q[4];
  assign b.o5  = q[5];
  assign b.o6  = q[6];
  assign b.o7  = q[7];
  assign b.o8  = q[8];
  assign b.o9  = q[9];
  assign b.o10 = q[10];
  assign b.o11 = q[11];
  assign b.o12 = q[12];
  assign b.o13 = q[13];
  assign b.o14 = q[14];
  assign b.o15 = q[15];
endmodule

// File: tb/tb_demux_if.sv
// Scoreboard bench for demux_if: expected output sets are queued
// when stimulus is driven and popped after the capturing edge.
module tb_demux_if;
  import demux_pkg::*;

  localparam int W = 8;

  typedef logic [15:0][W-1:0] outs_t;

  logic clk;
  logic rst;
  int   nvec;
  int   nerr;
  outs_t obs;
  outs_t last;
  outs_t sbq [$];

  demux_if_if #(.width(W)) bus ();

  demux_if #(.width(W), .snum(4)) dut (
    .clk(clk),
    .rst(rst),
    .b  (bus.slave)
  );

  assign obs[0]  = bus.o0;
  assign obs[1]  = bus.o1;
  assign obs[2]  = bus.o2;
  assign obs[3]  = bus.o3;
  assign obs[4]  = bus.o4;
  assign obs[5]  = bus.o5;
  assign obs[6]  = bus.o6;
  assign obs[7]  = bus.o7;
  assign obs[8]  = bus.o8;
  assign obs[9]  = bus.o9;
  assign obs[10] = bus.o10;
  assign obs[11] = bus.o11;
  assign obs[12] = bus.o12;
  assign obs[13] = bus.o13;
  assign obs[14] = bus.o14;
  assign obs[15] = bus.o15;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [W-1:0] got,
                       input logic [W-1:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic outs_t model(input logic r,
                                  input logic [W-1:0] d,
                                  input logic [3:0] s);
    outs_t m;
    m = '0;
    if (!r && !$isunknown(s)) m[s] = d;
    return m;
  endfunction

  task automatic step(input logic r,
                      input logic [W-1:0] d,
                      input logic [3:0] s,
                      input string tag);
    outs_t e;
    rst     = r;
    bus.i   = d;
    bus.sel = s;
    sbq.push_back(model(r, bus.i, bus.sel));
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      nvec++;
      nerr++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sbq.pop_front();
      for (int k = 0; k < 16; k++)
        check($sformatf("%s o%0d", tag, k), obs[k], e[k]);
      last = e;
    end
  endtask

  logic [W-1:0] sw_d [16];

  initial begin
    nvec = 0;
    nerr = 0;
    last = '0;
    rst = 1'b1;
    bus.i = '0;
    bus.sel = '0;
    sw_d = '{8'hA0, 8'hB0, 8'hC0, 8'hD0, 8'hE0, 8'hF0, 8'hA0, 8'hB0,
             8'hA0, 8'hB0, 8'hC0, 8'hD0, 8'hE0, 8'hF0, 8'hA0, 8'hB0};
    #1;

    step(1'b1, 8'hFF, 4'd5, "reset");
    step(1'b1, 8'hFF, 4'd5, "reset");

    for (int s = 0; s < 16; s++)
      for (int h = 0; h < 3; h++)
        step(1'b0, sw_d[s], 4'(s), $sformatf("sweep%0d", s));

    step(1'b0, 8'hD0, 4'd3, "lat_pre");
    rst = 1'b0;
    bus.i = 8'hD0;
    bus.sel = 4'd12;
    #1;
    check("lat_hold o3", obs[3], last[3]);
    check("lat_hold o12", obs[12], last[12]);
    step(1'b0, 8'hD0, 4'd12, "lat_post");

    step(1'b0, 8'hB0, 4'd9, "mid_load");
    step(1'b1, 8'hB0, 4'd9, "mid_rst");
    step(1'b0, 8'hB0, 4'd9, "mid_rel");

    step(1'b0, 8'hC0, 4'd4, "pre_x");
    step(1'b0, 8'hC0, 4'bx10x, "sel_x");

    step(1'b0, 8'h00, 4'd15, "zero");
    step(1'b0, 8'hFF, 4'd15, "full");

    for (int n = 0; n < 20; n++)
      step(1'b0, W'($urandom), 4'($urandom_range(0, 15)), "rand");

    if (sbq.size() != 0) begin
      nvec++;
      nerr++;
      $display("FAIL sbq_drain: got %0d want 0", sbq.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule
